// File: rtl/adc_sar_ctrl.sv
// Successive-approximation ADC controller: 8-bit binary search against an external
// comparator, with single-channel or 4-channel scan sequencing.
module adc_sar_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       start,
   input  logic       scan_en,
   input  logic [1:0] chan_sel,
   input  logic       cmp_in,
   output logic [7:0] dac_code,
   output logic [1:0] chan_mux,
   output logic       busy,
   output logic       done,
   output logic [7:0] DOut0,
   output logic [7:0] DOut1,
   output logic [7:0] DOut2,
   output logic [7:0] DOut3
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StSetup = 2'd1;
   localparam logic [1:0] StTrial = 2'd2;
   localparam logic [1:0] StStore = 2'd3;

   localparam logic [3:0] SettleLast = 4'(SETTLE);

   logic [1:0] state_q, state_d;
   logic       scan_q, scan_d;
   logic [1:0] chan_q, chan_d;
   logic [2:0] bit_q, bit_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] code_q, code_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] dout_q [4];
   logic [7:0] dout_d [4];

   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      chan_d  = chan_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               scan_d  = scan_en;
               chan_d  = scan_en ? 2'd0 : chan_sel;
               state_d = StSetup;
               busy_d  = 1'b1;
               code_d  = 8'h00;
               bit_d   = 3'd7;
               cnt_d   = 4'd0;
            end
         end
         StSetup: begin
            state_d = StTrial;
            code_d  = 8'h80;
            cnt_d   = 4'd0;
         end
         StTrial: begin
            // cmp_in only matters on the last edge of each bit period
            if (cnt_q == SettleLast) begin
               cnt_d = 4'd0;
               if (!cmp_in) begin
                  code_d[bit_q] = 1'b0;
               end
               if (bit_q == 3'd0) begin
                  state_d = StStore;
               end else begin
                  bit_d                 = bit_q - 3'd1;
                  code_d[bit_q - 3'd1]  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StStore: begin
            dout_d[chan_q] = code_q;
            if (scan_q && (chan_q != 2'd3)) begin
               chan_d  = chan_q + 2'd1;
               state_d = StSetup;
               code_d  = 8'h00;
               bit_d   = 3'd7;
            end else begin
               state_d = StIdle;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         scan_q  <= 1'b0;
         chan_q  <= 2'd0;
         bit_q   <= 3'd0;
         cnt_q   <= 4'd0;
         code_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '{default: 8'h00};
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         chan_q  <= chan_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
      end
   end

   assign dac_code = code_q;
   assign chan_mux = chan_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign DOut0    = dout_q[0];
   assign DOut1    = dout_q[1];
   assign DOut2    = dout_q[2];
   assign DOut3    = dout_q[3];

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Bench for adc_sar_ctrl: ideal comparator per channel, binary-search reference model.
module tb_adc_sar_ctrl;

   logic       mclk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       scan_en = 1'b0;
   logic [1:0] chan_sel = 2'd0;
   logic       cmp_in;
   logic [7:0] dac_code;
   logic [1:0] chan_mux;
   logic       busy, done;
   logic [7:0] dout0, dout1, dout2, dout3;

   logic [7:0] vin [4];
   logic [7:0] exp_dout [4];
   logic [7:0] tr_code [128];
   logic [1:0] tr_mux [128];
   logic       tr_busy [128];
   int         dones[$];
   int         n_checks = 0;
   int         n_errs = 0;

   adc_sar_ctrl #(.SETTLE(2)) dut (
      .mclk(mclk), .reset(reset), .start(start), .scan_en(scan_en), .chan_sel(chan_sel),
      .cmp_in(cmp_in), .dac_code(dac_code), .chan_mux(chan_mux), .busy(busy), .done(done),
      .DOut0(dout0), .DOut1(dout1), .DOut2(dout2), .DOut3(dout3)
   );

   assign cmp_in = (vin[chan_mux] >= dac_code);

   always #5 mclk = ~mclk;

   function automatic logic [7:0] dout_of(input int i);
      case (i)
         0: return dout0;
         1: return dout1;
         2: return dout2;
         default: return dout3;
      endcase
   endfunction

   // Binary search: trial p (0 = MSB) adds bit 7-p to the code kept so far
   function automatic logic [7:0] trial_at(input logic [7:0] v, input int p);
      logic [7:0] code = 8'h00;
      logic [7:0] t = 8'h00;
      for (int i = 0; i <= p; i++) begin
         t = code | (8'h80 >> i);
         if (v >= t) code = t;
      end
      return t;
   endfunction

   function automatic logic [7:0] sar_result(input logic [7:0] v);
      logic [7:0] code = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (v >= (code | (8'h01 << i))) code = code | (8'h01 << i);
      end
      return code;
   endfunction

   // E0 is the edge that samples start; trace index k holds outputs just after edge E0+k
   task automatic do_conv(input logic s, input logic [1:0] ch, input int cycles,
                          input int poke_at, input int hold);
      dones.delete();
      @(negedge mclk);
      start = 1'b1; scan_en = s; chan_sel = ch;
      @(posedge mclk); #1;
      tr_code[0] = dac_code; tr_mux[0] = chan_mux; tr_busy[0] = busy;
      if (hold == 0) begin
         start = 1'b0; chan_sel = 2'($urandom); scan_en = 1'($urandom);
      end
      for (int k = 1; k <= cycles; k++) begin
         @(posedge mclk); #1;
         tr_code[k] = dac_code; tr_mux[k] = chan_mux; tr_busy[k] = busy;
         if (done) dones.push_back(k);
         if (poke_at > 0 && k == poke_at) begin
            start = 1'b1; chan_sel = 2'd1; scan_en = 1'b1;
         end else if (poke_at > 0 && k == poke_at + 1) begin
            start = 1'b0;
         end
         if (hold > 0 && k == hold) start = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({dac_code, chan_mux, busy, done, dout0, dout1, dout2, dout3} !== 44'h0) begin
         n_errs++;
         $display("FAIL reset_state: got code=%h mux=%0d busy=%b done=%b douts=%h %h %h %h, want all 0",
                  dac_code, chan_mux, busy, done, dout0, dout1, dout2, dout3);
      end
      repeat (2) @(posedge mclk);
      @(negedge mclk) reset = 1'b0;
      for (int i = 0; i < 4; i++) exp_dout[i] = 8'h00;
   endtask

   task automatic test_single;
      vin[2] = 8'hA5;
      do_conv(1'b0, 2'd2, 32, 0, 0);
      exp_dout[2] = sar_result(8'hA5);
      n_checks++;
      if (dones.size() != 1 || dones[0] != 26) begin
         n_errs++;
         $display("FAIL single_done: got %0d pulses first at %0d, want 1 at 26",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1);
      end
      for (int p = 0; p < 8; p++) begin
         n_checks++;
         if (tr_code[1 + 3 * p] !== trial_at(8'hA5, p)) begin
            n_errs++;
            $display("FAIL single_trial%0d: got %h want %h", p, tr_code[1 + 3 * p],
                     trial_at(8'hA5, p));
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dout_of(i) !== exp_dout[i]) begin
            n_errs++;
            $display("FAIL single_dout%0d: got %h want %h", i, dout_of(i), exp_dout[i]);
         end
      end
      n_checks++;
      if (tr_busy[25] !== 1'b1 || tr_busy[26] !== 1'b0 || tr_code[31] !== 8'hA5 ||
          tr_mux[31] !== 2'd2) begin
         n_errs++;
         $display("FAIL single_idle_hold: busy25=%b busy26=%b code=%h mux=%0d want 1 0 a5 2",
                  tr_busy[25], tr_busy[26], tr_code[31], tr_mux[31]);
      end
   endtask

   task automatic test_boundaries;
      logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'h80};
      for (int j = 0; j < 3; j++) begin
         vin[0] = vals[j];
         do_conv(1'b0, 2'd0, 28, 0, 0);
         exp_dout[0] = sar_result(vals[j]);
         n_checks++;
         if (dout0 !== vals[j] || dout0 !== exp_dout[0]) begin
            n_errs++;
            $display("FAIL boundary_%h: got %h want %h", vals[j], dout0, vals[j]);
         end
      end
   endtask

   task automatic test_random_single;
      for (int r = 0; r < 6; r++) begin
         logic [1:0] ch = 2'($urandom);
         for (int i = 0; i < 4; i++) vin[i] = 8'($urandom);
         do_conv(1'b0, ch, 28, 0, 0);
         exp_dout[ch] = sar_result(vin[ch]);
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dout_of(i) !== exp_dout[i]) begin
               n_errs++;
               $display("FAIL rand%0d_dout%0d: got %h want %h", r, i, dout_of(i), exp_dout[i]);
            end
         end
      end
   endtask

   task automatic test_scan(input logic [7:0] v0, input logic [7:0] v1,
                            input logic [7:0] v2, input logic [7:0] v3);
      int low = 0;
      vin[0] = v0; vin[1] = v1; vin[2] = v2; vin[3] = v3;
      do_conv(1'b1, 2'($urandom), 110, 0, 0);
      for (int i = 0; i < 4; i++) exp_dout[i] = sar_result(vin[i]);
      n_checks++;
      if (dones.size() != 1 || dones[0] != 104) begin
         n_errs++;
         $display("FAIL scan_done: got %0d pulses first at %0d, want 1 at 104",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1);
      end
      for (int k = 0; k < 104; k++) if (tr_busy[k] !== 1'b1) low++;
      n_checks++;
      if (low != 0 || tr_busy[104] !== 1'b0) begin
         n_errs++;
         $display("FAIL scan_busy: got %0d low cycles, busy104=%b, want 0 and 0", low,
                  tr_busy[104]);
      end
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (tr_mux[26 * c] !== 2'(c) || tr_mux[26 * c + 13] !== 2'(c)) begin
            n_errs++;
            $display("FAIL scan_mux%0d: got %0d/%0d want %0d", c, tr_mux[26 * c],
                     tr_mux[26 * c + 13], c);
         end
         n_checks++;
         if (dout_of(c) !== exp_dout[c]) begin
            n_errs++;
            $display("FAIL scan_dout%0d: got %h want %h", c, dout_of(c), exp_dout[c]);
         end
      end
   endtask

   task automatic test_ignore_start;
      vin[1] = 8'($urandom); vin[2] = 8'($urandom);
      // start rises before edge E0+5 with chan_sel=1 and scan_en=1
      do_conv(1'b0, 2'd2, 30, 4, 0);
      exp_dout[2] = sar_result(vin[2]);
      n_checks++;
      if (dones.size() != 1 || dones[0] != 26) begin
         n_errs++;
         $display("FAIL ignore_done: got %0d pulses first at %0d, want 1 at 26",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dout_of(i) !== exp_dout[i]) begin
            n_errs++;
            $display("FAIL ignore_dout%0d: got %h want %h", i, dout_of(i), exp_dout[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      vin[3] = 8'($urandom);
      do_conv(1'b0, 2'd3, 12, 0, 0);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({dac_code, chan_mux, busy, done, dout0, dout1, dout2, dout3} !== 44'h0) begin
         n_errs++;
         $display("FAIL reset_mid: got code=%h mux=%0d busy=%b done=%b douts=%h %h %h %h, want all 0",
                  dac_code, chan_mux, busy, done, dout0, dout1, dout2, dout3);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) exp_dout[i] = 8'h00;
      vin[1] = 8'h3C;
      do_conv(1'b0, 2'd1, 30, 0, 0);
      exp_dout[1] = sar_result(8'h3C);
      n_checks++;
      if (dones.size() != 1 || dones[0] != 26 || tr_busy[0] !== 1'b1) begin
         n_errs++;
         $display("FAIL reset_recover_done: got %0d pulses first at %0d busy0=%b, want 1 at 26 busy0=1",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1, tr_busy[0]);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dout_of(i) !== exp_dout[i]) begin
            n_errs++;
            $display("FAIL reset_recover_dout%0d: got %h want %h", i, dout_of(i), exp_dout[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      vin[0] = 8'($urandom);
      do_conv(1'b0, 2'd0, 85, 0, 60);
      exp_dout[0] = sar_result(vin[0]);
      n_checks++;
      if (dones.size() != 3 || dones[0] != 26 || dones[1] != 53 || dones[2] != 80) begin
         n_errs++;
         $display("FAIL b2b_done: got %0d pulses at %0d %0d, want 3 at 26 53 (80)",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1,
                  (dones.size() > 1) ? dones[1] : -1);
      end
      n_checks++;
      if (tr_busy[26] !== 1'b0 || tr_busy[27] !== 1'b1 || dout0 !== exp_dout[0]) begin
         n_errs++;
         $display("FAIL b2b_dwell: busy26=%b busy27=%b dout0=%h, want 0 1 %h",
                  tr_busy[26], tr_busy[27], dout0, exp_dout[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) vin[i] = 8'h00;
      test_reset;
      test_single;
      test_boundaries;
      test_random_single;
      test_scan(8'h12, 8'h34, 8'h56, 8'h78);
      test_scan(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      test_ignore_start;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
